uart_byte_packer: RTL
=====================

// Module: uart_byte_packer
// PURPOSE
//   Sits directly downstream of the UART receiver; consumes its 8-bit byte strobe.
//   Packs received bytes pairwise into 16-bit words, SDRAM data width, first byte = low byte.
//   Buffers words in a small first-word-fall-through FIFO.
//   Presents words to the SDRAM write path via a valid/ready handshake.
//   A lone byte left waiting after an idle gap is flushed zero-padded.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   UART_BPS    9600        UART baud rate, used only for the idle timeout
//   FIFO_DEPTH  8           word FIFO depth; power of 2, >= 2
//   IDLE_BYTES  2           idle gap before odd-byte flush, in 10-bit character times
// PORTS
//   sys_clk      in   1                    system clock, rising edge
//   sys_rst_n    in   1                    reset, asynchronous, active-low
//   pi_data      in   8                    received byte; valid when pi_flag=1
//   pi_flag      in   1                    one-cycle byte strobe from the UART receiver
//   wr_ready     in   1                    downstream accepts wr_data this cycle
//   clr_overflow in   1                    one-cycle clear of the overflow flag
//   wr_data      out  16                   head-of-FIFO word, {second byte, first byte}
//   wr_valid     out  1                    FIFO not empty
//   fifo_cnt     out  log2(FIFO_DEPTH)+1   words currently stored
//   overflow     out  1                    sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//   Reset: all outputs 0; pairing state EMPTY; pointers, count, timer and FIFO storage cleared.
//   Reset mid-operation discards the held byte and all stored words.
//   Constant: TIMEOUT_CYC = IDLE_BYTES*10*(CLK_FREQ/UART_BPS), which is 104160 at defaults.
//     The timer is 20 bits; TIMEOUT_CYC < 2^20 is required.
//   Pairing FSM, two states:
//     EMPTY, pi_flag: latch pi_data as low byte; clear timer; go to HALF.
//     HALF, pi_flag: push {pi_data, low}; go to EMPTY.
//     HALF, no pi_flag: timer += 1. When timer == TIMEOUT_CYC-1, push {8'h00, low}; go to EMPTY.
//     HALF, pi_flag on the expiry cycle: the byte pairs normally; no pad word is generated.
//   FIFO, first-word-fall-through:
//     Push is registered; a word pushed on cycle N appears at wr_data with wr_valid=1 on N+1.
//     wr_valid = (fifo_cnt != 0). wr_data = storage[rd_ptr], driven combinationally from the registers.
//     Pop happens when wr_valid && wr_ready. wr_data must stay stable while wr_valid=1 and wr_ready=0.
//     Pointers are log2(FIFO_DEPTH) bits and wrap naturally; fifo_cnt is tracked separately.
//   Push and pop on the same cycle: both are performed; fifo_cnt is unchanged. This also holds when full.
//   Push while full without a pop: the word is dropped; overflow <= 1; storage is unchanged.
//   Pop while empty: ignored, since wr_valid=0.
//   Overflow flag:
//     Sticky until clr_overflow=1.
//     A set event on the same cycle as clr_overflow wins; overflow stays 1.
//   No flow control back to the UART; bytes are never stalled, only dropped.
// TESTING
//   1. Strobe 0x34 then 0x12, 20 cycles apart, wr_ready=1.
//      -> wr_valid=1 one cycle after the 2nd strobe, wr_data=16'h1234, popped; fifo_cnt returns to 0.
//   2. Single strobe 0xAB, then idle, wr_ready=0.
//      -> exactly TIMEOUT_CYC cycles later, wr_data=16'h00AB, wr_valid=1, fifo_cnt=1.
//   3. wr_ready=0; send 18 bytes 0x00..0x11.
//      -> fifo_cnt=8, overflow=1.
//      -> then wr_ready=1 drains 0x0100, 0x0302, ... 0x0F0E in order; 0x1110 is lost.
//   4. FIFO full, completing byte strobed on the same cycle as wr_ready=1.
//      -> push accepted, fifo_cnt stays 8, overflow stays 0, new word is last out.
//   5. Pulse sys_rst_n low while in HALF holding 0x55; then send 0x66, 0x77.
//      -> single word 16'h7766, no pad word, overflow=0.
//   6. Second byte strobe lands exactly on the timeout-expiry cycle; clr_overflow pulsed with a drop.
//      -> paired word, no 0x00 pad; overflow remains 1.

Source files
------------

// File: rtl/uart_byte_packer.sv
// Packs UART receive bytes pairwise into 16-bit words (first byte low) and queues them in a
// first-word-fall-through FIFO that feeds the SDRAM write path over a valid/ready handshake.
module uart_byte_packer #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned IDLE_BYTES = 2,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [7:0]    pi_data,
    input  logic          pi_flag,
    input  logic          wr_ready,
    input  logic          clr_overflow,
    output logic [15:0]   wr_data,
    output logic          wr_valid,
    output logic [CW-1:0] fifo_cnt,
    output logic          overflow
);

    // Idle gap after which a lone byte is flushed; must fit the 20-bit timer.
    localparam int unsigned TIMEOUT_CYC = IDLE_BYTES * 10 * (CLK_FREQ / UART_BPS);
    localparam logic [19:0] TimerLast   = 20'(TIMEOUT_CYC - 1);

    typedef enum logic {StEmpty, StHalf} state_e;

    state_e        state_q, state_d;
    logic [7:0]    low_q, low_d;
    logic [19:0]   timer_q, timer_d;
    logic          push;
    logic [15:0]   push_word;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          full, do_pop, do_write, drop;

    // Pairing FSM: state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StEmpty;
            low_q   <= 8'h00;
            timer_q <= 20'd0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            timer_q <= timer_d;
        end
    end

    // Pairing FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (pi_flag) state_d = StHalf;
            StHalf:  if (pi_flag || (timer_q == TimerLast)) state_d = StEmpty;
        endcase
    end

    // Pairing FSM: outputs and datapath; a strobe on the expiry cycle pairs, no pad.
    always_comb begin
        push      = 1'b0;
        push_word = 16'h0000;
        low_d     = low_q;
        timer_d   = timer_q;
        unique case (state_q)
            StEmpty: begin
                if (pi_flag) begin
                    low_d   = pi_data;
                    timer_d = 20'd0;
                end
            end
            StHalf: begin
                if (pi_flag) begin
                    push      = 1'b1;
                    push_word = {pi_data, low_q};
                end else if (timer_q == TimerLast) begin
                    push      = 1'b1;
                    push_word = {8'h00, low_q};
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end
        endcase
    end

    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign do_pop   = wr_valid && wr_ready;
    // A pop frees a slot this cycle, so a push into a full FIFO is still taken.
    assign do_write = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_write, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            if (do_write) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign wr_valid = (cnt_q != '0);
    assign wr_data  = mem_q[rd_ptr_q];
    assign fifo_cnt = cnt_q;
    assign overflow = overflow_q;

endmodule
